// File: rtl/adc_sample_sequencer.sv
`timescale 1ns/1ps
// adc_sample_sequencer
//   Initiator side of a SAR ADC start/done handshake. A programmable tick
//   generator requests conversions. Each conversion is started with a one-cycle
//   adc_start pulse and completes on the rising edge of adc_done. 2**AVG_LOG2
//   results are summed and the truncated mean is pushed into a small
//   first-word-fall-through FIFO that feeds the consumer.
//
// Ports
//   clk, rst            clock (rising edge) and asynchronous active-high reset
//   en                  1 = sampling enabled
//   period              clk cycles between conversion requests (0 acts as 1)
//   clr_err             pulse clearing the sticky overflow / timeout_err flags
//   adc_start           one-cycle conversion start pulse to the ADC
//   adc_done, adc_data  ADC done level and 8-bit result (valid on done rise)
//   smp_data, smp_valid averaged sample at FIFO head, FIFO non-empty
//   smp_ready           consumer acceptance
//   busy                sequencer FSM not idle
//   overflow            sticky: an averaged sample was dropped (FIFO full)
//   timeout_err         sticky: no done within TIMEOUT cycles of a start
//
// Output handshake: a sample transfers on every rising clk edge where
//   smp_valid & smp_ready are both 1. smp_valid never depends on smp_ready, and
//   while smp_valid=1 and smp_ready=0 the head entry (smp_data) holds steady.
module adc_sample_sequencer #(
  parameter int PERIOD_W   = 16,
  parameter int AVG_LOG2   = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [PERIOD_W-1:0] period,
  input  logic                clr_err,
  output logic                adc_start,
  input  logic                adc_done,
  input  logic [7:0]          adc_data,
  output logic [7:0]          smp_data,
  output logic                smp_valid,
  input  logic                smp_ready,
  output logic                busy,
  output logic                overflow,
  output logic                timeout_err
);

  localparam int ACC_W = 8 + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] AVG_N   = CNT_W'(1 << AVG_LOG2);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_PUSH  = 2'd3;

  // ---------------------------------------------------------------------------
  // Tick generator and pending request
  // ---------------------------------------------------------------------------
  logic [PERIOD_W-1:0] tick_cnt;
  logic [PERIOD_W-1:0] period_max;
  logic                tick;
  logic                pending;
  logic                take;
  logic [1:0]          state;

  assign period_max = (period == '0) ? PERIOD_W'(1) : period;
  // ">=" so that shrinking period on the fly cannot strand the counter above
  // the new terminal value.
  assign tick = en & (tick_cnt >= (period_max - PERIOD_W'(1)));

  // The IDLE state consumes a tick in the same cycle it fires, which gives the
  // one-cycle tick-to-adc_start latency.
  assign take = (state == S_IDLE) & en & (pending | tick);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (!en || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + PERIOD_W'(1);
    end
  end

  // A tick that fires while a request is already pending is simply lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= 1'b0;
    end else if (!en || take) begin
      pending <= 1'b0;
    end else if (tick) begin
      pending <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Done edge detect
  // ---------------------------------------------------------------------------
  logic done_q;
  logic done_edge;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q <= 1'b0;
    end else begin
      done_q <= adc_done;
    end
  end

  assign done_edge = adc_done & ~done_q;

  // ---------------------------------------------------------------------------
  // Conversion FSM and accumulator
  // ---------------------------------------------------------------------------
  logic [1:0]       state_nxt;
  logic [ACC_W-1:0] acc, acc_nxt, acc_sum;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic [TO_W-1:0]  tcnt, tcnt_nxt;
  logic             push;
  logic             to_set;
  logic [7:0]       push_data;

  assign acc_sum   = acc + ACC_W'(adc_data);
  assign cnt_inc   = cnt + CNT_W'(1);
  assign push_data = 8'(acc >> AVG_LOG2);

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    tcnt_nxt  = tcnt;
    push      = 1'b0;
    to_set    = 1'b0;
    case (state)
      S_IDLE: begin
        // Disabling while idle discards any partial average.
        if (!en) begin
          acc_nxt = '0;
          cnt_nxt = '0;
        end
        if (take) begin
          state_nxt = S_START;
        end
      end
      S_START: begin
        tcnt_nxt  = '0;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        tcnt_nxt = tcnt + TO_W'(1);
        // A done edge in the last allowed cycle still counts as a result.
        if (done_edge) begin
          acc_nxt   = acc_sum;
          cnt_nxt   = cnt_inc;
          state_nxt = (cnt_inc == AVG_N) ? S_PUSH : S_IDLE;
        end else if (tcnt == TO_LAST) begin
          to_set    = 1'b1;
          acc_nxt   = '0;
          cnt_nxt   = '0;
          state_nxt = S_IDLE;
        end
      end
      S_PUSH: begin
        push      = 1'b1;
        acc_nxt   = '0;
        cnt_nxt   = '0;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      acc   <= '0;
      cnt   <= '0;
      tcnt  <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      tcnt  <= tcnt_nxt;
    end
  end

  assign adc_start = (state == S_START);
  assign busy      = (state != S_IDLE);

  // ---------------------------------------------------------------------------
  // Output FIFO (first-word-fall-through)
  // ---------------------------------------------------------------------------
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [7:0]     mem [FIFO_DEPTH];
  logic [PTR_W:0] wr_ptr, rd_ptr;
  logic           empty, full, pop, wr_en, ovf_set;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign pop   = smp_valid & smp_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is
  // accepted when the head is leaving.
  assign wr_en   = push & (~full | pop);
  assign ovf_set = push & full & ~pop;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[PTR_W-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      end
    end
  end

  assign smp_valid = ~empty;
  // Storage is not reset; gating keeps smp_data at 0 whenever nothing is held.
  assign smp_data  = smp_valid ? mem[rd_ptr[PTR_W-1:0]] : 8'h00;

  // ---------------------------------------------------------------------------
  // Sticky error flags: a set in the same cycle as clr_err wins.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      overflow    <= ovf_set | (overflow & ~clr_err);
      timeout_err <= to_set | (timeout_err & ~clr_err);
    end
  end

endmodule

// File: tb/tb_adc_sample_sequencer.sv
`timescale 1ns/1ps
// Directed bench for adc_sample_sequencer. Two instances share all inputs:
// u_dut averages 4 conversions (AVG_LOG2=2), u_dut0 passes each conversion
// through (AVG_LOG2=0). A behavioural ADC answers u_dut's adc_start.
module tb_adc_sample_sequencer;

  // ---------------------------------------------------------------- clock/reset
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic        en = 1'b0;
  logic [15:0] period = 16'd10;
  logic        clr_err = 1'b0;
  logic        adc_start, adc_done = 1'b0;
  logic [7:0]  adc_data = 8'h00;
  logic [7:0]  smp_data;
  logic        smp_valid, smp_ready = 1'b1;
  logic        busy, overflow, timeout_err;

  logic        adc_start0, smp_valid0, busy0, overflow0, timeout_err0;
  logic [7:0]  smp_data0;
  logic        ready0 = 1'b1;

  adc_sample_sequencer #(.PERIOD_W(16), .AVG_LOG2(2), .FIFO_DEPTH(4), .TIMEOUT(64)) u_dut (
    .clk(clk), .rst(rst), .en(en), .period(period), .clr_err(clr_err),
    .adc_start(adc_start), .adc_done(adc_done), .adc_data(adc_data),
    .smp_data(smp_data), .smp_valid(smp_valid), .smp_ready(smp_ready),
    .busy(busy), .overflow(overflow), .timeout_err(timeout_err)
  );

  adc_sample_sequencer #(.PERIOD_W(16), .AVG_LOG2(0), .FIFO_DEPTH(4), .TIMEOUT(64)) u_dut0 (
    .clk(clk), .rst(rst), .en(en), .period(period), .clr_err(clr_err),
    .adc_start(adc_start0), .adc_done(adc_done), .adc_data(adc_data),
    .smp_data(smp_data0), .smp_valid(smp_valid0), .smp_ready(ready0),
    .busy(busy0), .overflow(overflow0), .timeout_err(timeout_err0)
  );

  // ---------------------------------------------------------------- counters
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- ADC model
  // Acts just after each rising edge. adc_done drops when a new start is seen
  // and rises adc_dly cycles later (counting the start cycle as cycle 0),
  // carrying the next queued value or adc_dflt.
  int         adc_dly = 7;
  bit         adc_respond = 1'b1;
  logic [7:0] adc_dflt = 8'h5A;
  logic [7:0] data_q[$];
  int         adc_k = -1;

  always @(posedge clk) begin
    #1;
    if (adc_start) begin
      adc_done = 1'b0;
      adc_k = 0;
    end else if (adc_k >= 0) begin
      adc_k++;
      if (adc_k == adc_dly) begin
        if (adc_respond) begin
          adc_data = (data_q.size() > 0) ? data_q.pop_front() : adc_dflt;
          adc_done = 1'b1;
        end
        adc_k = -1;
      end
    end
  end

  // ---------------------------------------------------------------- scoreboard
  logic [7:0] exp_q[$];
  int pops2 = 0;
  int pops0 = 0;
  bit mon0_on = 1'b0;

  always @(negedge clk) begin
    #1;
    if (!rst && smp_valid && smp_ready) begin
      pops2++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_sample: got 0x%0h, expected none at %0t", smp_data, $time);
      end else begin
        check("sample_data", {24'h0, smp_data}, {24'h0, exp_q.pop_front()});
      end
    end
    if (!rst && mon0_on && smp_valid0) begin
      pops0++;
      check("avg0_sample", {24'h0, smp_data0}, 32'h5A);
    end
  end

  // ---------------------------------------------------------------- drivers
  // Advances to the negedge of the next cycle with adc_start high; n counts
  // the negedges taken.
  task automatic wait_start(input int budget, output int n);
    bit found = 1'b0;
    n = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      n++;
      if (adc_start) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL wait_start: no adc_start within %0d cycles, expected one", budget);
    end
  endtask

  task automatic wait_done(input int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (adc_done) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL wait_done: no adc_done within %0d cycles, expected one", budget);
    end
  endtask

  // Exactly four conversions: en is dropped on the fourth start so that the
  // last conversion completes and nothing further starts. With pulse set,
  // smp_ready is high only in the PUSH cycle (the cycle after the done edge).
  task automatic run_group(input logic [7:0] d0, input logic [7:0] d1,
                           input logic [7:0] d2, input logic [7:0] d3,
                           input bit pulse, output int gap);
    int n;
    int pops_entry;
    data_q.push_back(d0);
    data_q.push_back(d1);
    data_q.push_back(d2);
    data_q.push_back(d3);
    pops_entry = pops2;
    gap = 0;
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_start(200, n);
      if (i == 1) gap = n;
    end
    en = 1'b0;
    check("no_early_sample", pops2, pops_entry);
    wait_done(50);
    if (pulse) begin
      @(negedge clk);
      smp_ready = 1'b1;
      @(negedge clk);
      smp_ready = 1'b0;
    end
    repeat (4) @(negedge clk);
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct packed {
    logic [7:0] d0, d1, d2, d3;
    logic [7:0] avg;
  } vec_t;

  vec_t tbl[6];

  // ---------------------------------------------------------------- test
  initial begin
    int n, n2, gap;

    tbl[0] = '{d0: 8'd10,  d1: 8'd11,  d2: 8'd12,  d3: 8'd14,  avg: 8'h0B};
    tbl[1] = '{d0: 8'd0,   d1: 8'd0,   d2: 8'd0,   d3: 8'd3,   avg: 8'd0};
    tbl[2] = '{d0: 8'd255, d1: 8'd255, d2: 8'd255, d3: 8'd255, avg: 8'd255};
    tbl[3] = '{d0: 8'd1,   d1: 8'd2,   d2: 8'd3,   d3: 8'd5,   avg: 8'd2};
    tbl[4] = '{d0: 8'd128, d1: 8'd0,   d2: 8'd0,   d3: 8'd0,   avg: 8'd32};
    tbl[5] = '{d0: 8'd200, d1: 8'd100, d2: 8'd50,  d3: 8'd25,  avg: 8'd93};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_adc_start", adc_start, 0);
    check("rst_busy", busy, 0);
    check("rst_smp_valid", smp_valid, 0);
    check("rst_smp_data", smp_data, 0);
    check("rst_overflow", overflow, 0);
    check("rst_timeout_err", timeout_err, 0);
    rst = 1'b0;
    @(negedge clk);

    // period=10, done 7 cycles after the start cycle, data 0x5A. The whole
    // START/WAIT/PUSH/IDLE loop fits in 10 cycles, so starts are exactly
    // 10 apart; AVG_LOG2=0 passes 0x5A straight through.
    mon0_on = 1'b1;
    exp_q.push_back(8'h5A);
    en = 1'b1;
    wait_start(50, n);
    check("first_start_latency", n, 10);
    for (int i = 0; i < 3; i++) begin
      wait_start(50, n);
      check("start_period10", n, 10);
      check("start_lockstep", adc_start0, 1);
    end
    en = 1'b0;
    check("busy_in_conversion", busy, 1);
    check("avg4_none_before_4th", pops2, 0);
    n2 = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (adc_start) n2++;
    end
    check("no_start_after_en_low", n2, 0);
    check("avg0_samples", pops0, 4);
    check("avg4_samples", pops2, 1);
    check("avg4_queue_drained", exp_q.size(), 0);
    check("busy0_idle", busy0, 0);
    check("overflow0", overflow0, 0);
    check("timeout_err0", timeout_err0, 0);
    check("busy_idle", busy, 0);
    mon0_on = 1'b0;

    // Averaging table, period=0 (back-to-back), done 3 cycles after start
    period = 16'd0;
    adc_dly = 3;
    for (int v = 0; v < 6; v++) begin
      exp_q.push_back(tbl[v].avg);
      run_group(tbl[v].d0, tbl[v].d1, tbl[v].d2, tbl[v].d3, 1'b0, gap);
      if (v == 0) check("period0_gap", gap, 5);
      check("table_queue_drained", exp_q.size(), 0);
    end

    // FIFO fill, push+pop while full, overflow, drain
    smp_ready = 1'b0;
    exp_q.push_back(8'd16);
    exp_q.push_back(8'd2);
    exp_q.push_back(8'd101);
    exp_q.push_back(8'd7);
    exp_q.push_back(8'd251);
    run_group(8'd16, 8'd16, 8'd16, 8'd16, 1'b0, gap);
    run_group(8'd1, 8'd2, 8'd3, 8'd4, 1'b0, gap);
    run_group(8'd100, 8'd101, 8'd102, 8'd103, 1'b0, gap);
    run_group(8'd7, 8'd7, 8'd7, 8'd9, 1'b0, gap);
    check("full_valid", smp_valid, 1);
    check("full_head_stable", smp_data, 8'd16);
    check("full_no_overflow", overflow, 0);
    run_group(8'd250, 8'd251, 8'd252, 8'd253, 1'b1, gap);
    check("push_pop_full_no_overflow", overflow, 0);
    check("head_after_push_pop", smp_data, 8'd2);
    run_group(8'd3, 8'd3, 8'd3, 8'd3, 1'b0, gap);
    check("overflow_set", overflow, 1);
    check("head_stable_after_drop", smp_data, 8'd2);
    smp_ready = 1'b1;
    repeat (10) @(negedge clk);
    check("drain_queue_empty", exp_q.size(), 0);
    check("drain_valid_low", smp_valid, 0);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    check("overflow_cleared", overflow, 0);

    // Timeout: ADC never answers
    period = 16'd100;
    adc_respond = 1'b0;
    en = 1'b1;
    wait_start(150, n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n++;
      if (timeout_err) break;
    end
    check("timeout_latency", n, 65);
    wait_start(150, n2);
    check("restart_after_timeout", n + n2, 100);
    adc_respond = 1'b1;
    en = 1'b0;
    check("timeout_sticky", timeout_err, 1);
    repeat (8) @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    check("timeout_cleared", timeout_err, 0);

    // Reset in WAIT with two partials accumulated, plus a held sample
    period = 16'd0;
    smp_ready = 1'b0;
    run_group(8'd40, 8'd40, 8'd40, 8'd40, 1'b0, gap);
    check("held_before_reset", smp_valid, 1);
    data_q.push_back(8'd50);
    data_q.push_back(8'd60);
    data_q.push_back(8'd99);
    en = 1'b1;
    for (int i = 0; i < 3; i++) wait_start(50, n);
    @(negedge clk);
    rst = 1'b1;
    en = 1'b0;
    #1;
    check("mid_rst_adc_start", adc_start, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_smp_valid", smp_valid, 0);
    check("mid_rst_smp_data", smp_data, 0);
    check("mid_rst_overflow", overflow, 0);
    check("mid_rst_timeout_err", timeout_err, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("late_done_ignored_busy", busy, 0);
    check("late_done_ignored_valid", smp_valid, 0);
    smp_ready = 1'b1;
    exp_q.push_back(8'd20);
    run_group(8'd20, 8'd20, 8'd20, 8'd20, 1'b0, gap);
    check("post_reset_queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // ---------------------------------------------------------------- watchdog
  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
